button_ctl: RTL
===============

# button_ctl

Input conditioner that turns the four raw push-buttons into the one-cycle command pulses the Tetris game controller consumes on `button_left`, `button_right`, `button_down` and `button_rotate`. It sits between the board pins and the game controller, all in the `pclk` domain. Its job is to make each physical press, and each auto-repeat of a held move key, appear to the controller as exactly one clean, arbitrated pulse.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 650_000: consecutive stable cycles required to change a debounced level (10 ms at 65 MHz).
- `REPEAT_DELAY`, 19_500_000: cycles from a press pulse to the first auto-repeat (300 ms).
- `REPEAT_RATE`, 6_500_000: cycles between subsequent auto-repeats (100 ms).
- `CNT_W`, 25: counter width; must satisfy 2^CNT_W > max(all three above).

Ports:
- `pclk`, in, 1: single clock; everything is synchronous to it.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: high while the game accepts input; low during game over.
- `btn_left_raw`, `btn_right_raw`, `btn_down_raw`, `btn_rotate_raw`, in, 1 each: asynchronous, active-high, bouncing pins.
- `button_left`, `button_right`, `button_down`, `button_rotate`, out, 1 each: registered single-cycle pulses.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer, giving `s_x`.
- **Debounce:**
  - Each button has a debounced level `db_x` (reset 0) and a counter.
  - While `s_x != db_x`, the counter increments; at any cycle where `s_x == db_x`, the counter clears.
  - `db_x` toggles on the edge where the counter reaches `DEBOUNCE_CYCLES`; the counter clears on that same edge.
- **Per-button FSM** for left, right and down, with states RELEASED, HOLD, REPEAT:
  - RELEASED -> HOLD on a `db_x` rising edge. This sets `pend_x` and clears the repeat counter.
  - HOLD -> REPEAT when the repeat counter reaches `REPEAT_DELAY - 1`. This sets `pend_x` and clears the counter.
  - REPEAT: sets `pend_x` each time the counter reaches `REPEAT_RATE - 1`, then clears the counter.
  - HOLD or REPEAT -> RELEASED when `db_x` falls.
  - The rotate FSM has only RELEASED and HOLD. Rotate never auto-repeats.
- **Left/right conflict:** while `db_left` and `db_right` are both high, both left and right repeat counters freeze and no new left/right pending bits are set. Existing pending bits are kept. Counting resumes when one key is released.
- **Pending merge:** setting a `pend_x` that is already set has no additional effect.
- **Arbiter:** at most one output is high per cycle. Priority is left > right > down > rotate.
  - The winning pending bit is cleared on the edge that drives its output high.
  - Losing pending bits stay set and are served in later cycles.
  - Repeat schedules are not shifted by arbitration delay.
- **enable low:**
  - All pending bits are cleared and held at 0, and all outputs stay 0.
  - Debounce and FSMs keep tracking levels, but presses do not set pending bits.
  - Presses held across the rising edge of `enable` generate nothing until released and pressed again.

## Timing
- **Reset values:** all outputs 0. Synchronizers, `db_x`, pending bits and counters are 0; all FSMs are RELEASED.
- **Reset mid-hold:** a button still held after reset deasserts is treated as a fresh press once it debounces.
- **Press latency:** raw input rises and is stable from the sampling edge counted as edge 1:
  - `s_x` is high after edge 2.
  - `db_x` and `pend_x` are set on edge 2 + `DEBOUNCE_CYCLES`.
  - The output is high for exactly one cycle after edge 3 + `DEBOUNCE_CYCLES`, if uncontested.
- **Repeat spacing:** the first repeat pulse follows the press pulse by `REPEAT_DELAY` cycles; later repeat pulses are spaced `REPEAT_RATE` cycles apart.
- **Release:** the release takes effect `DEBOUNCE_CYCLES` + 2 cycles after the raw fall. No repeat pulse is generated after the edge on which `db_x` falls, but an already-pending pulse is still delivered.
- **Glitch filtering:** any raw glitch shorter than `DEBOUNCE_CYCLES` cycles at the synchronizer output produces no change.
- **Pulse gap:** consecutive pulses on the same output are at least 2 cycles apart, since `REPEAT_RATE` must be ≥ 2.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=8, `enable`=1 unless noted.
- **Clean press:** raise `btn_rotate_raw` for 10 cycles, then release -> one `button_rotate` pulse after edge 7; no further pulses, ever.
- **Bounce:** toggle `btn_left_raw` at 3-cycle intervals for 30 cycles, then hold high -> zero pulses during bouncing; exactly one pulse 7 cycles after the stable hold begins.
- **Auto-repeat:** hold `btn_down_raw` for 60 cycles -> pulses at cycles P, P+20, P+28, P+36, P+44, P+52 (P = 7); none after release takes effect.
- **Simultaneous press:** assert left, down and rotate on the same edge -> `button_left` at cycle 7, `button_down` at 8, `button_rotate` at 9; never two outputs high together.
- **Conflict and disable:**
  - Hold left, then add right at cycle 30 -> no new left/right pulses while both are held.
  - Drop `enable` with a pending bit set -> no pulse is emitted.
- **Reset:** assert `rst` for 1 cycle while down is held in REPEAT -> outputs are 0 on the next edge; a fresh press pulse appears 7 cycles after `rst` falls.

Source files
------------

// File: rtl/button_ctl.sv
// Push-button conditioner: synchronizes, debounces and auto-repeats four raw buttons
// and arbitrates them into single-cycle command pulses (left > right > down > rotate).
module button_ctl #(
    parameter int DEBOUNCE_CYCLES = 650_000,
    parameter int REPEAT_DELAY    = 19_500_000,
    parameter int REPEAT_RATE     = 6_500_000,
    parameter int CNT_W           = 25
) (
    input  logic pclk,
    input  logic rst,
    input  logic enable,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic btn_down_raw,
    input  logic btn_rotate_raw,
    output logic button_left,
    output logic button_right,
    output logic button_down,
    output logic button_rotate
);

    localparam int NB = 4;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2
    } btn_state_e;

    // Bit order everywhere: 0 left, 1 right, 2 down, 3 rotate (also the priority order).
    logic [NB-1:0] raw_w;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] db_q;
    logic [NB-1:0] db_d;
    logic [NB-1:0] db_rise;
    logic [NB-1:0] db_fall;
    logic [NB-1:0] set_pend;
    logic [NB-1:0] pend_q;
    logic [NB-1:0] pend_d;
    logic [NB-1:0] grant;
    logic [NB-1:0] out_q;
    logic          lr_conflict;

    assign raw_w = {btn_rotate_raw, btn_down_raw, btn_right_raw, btn_left_raw};

    always_ff @(posedge pclk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_w;
            sync2_q <= sync1_q;
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_db
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             lvl_q;
            logic             lvl_d;

            always_comb begin
                cnt_d = '0;
                lvl_d = lvl_q;
                if (sync2_q[gi] != lvl_q) begin
                    if (cnt_q == DB_LAST) begin
                        lvl_d = ~lvl_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge pclk) begin
                if (rst) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign db_q[gi]    = lvl_q;
            assign db_d[gi]    = lvl_d;
            assign db_rise[gi] = lvl_d & ~lvl_q;
            assign db_fall[gi] = ~lvl_d & lvl_q;
        end
    endgenerate

    // Uses the post-edge levels so a second key landing on the held one is itself silenced.
    assign lr_conflict = db_d[0] & db_d[1];

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_fsm
            localparam logic IS_LR      = (gi < 2);
            localparam logic CAN_REPEAT = (gi != 3);

            btn_state_e       state_q;
            btn_state_e       state_d;
            logic [CNT_W-1:0] rep_q;
            logic [CNT_W-1:0] rep_d;
            logic             mute_q;
            logic             mute_d;
            logic             fire;
            logic             freeze;

            assign freeze = IS_LR & lr_conflict;

            always_comb begin
                state_d = state_q;
                rep_d   = rep_q;
                fire    = 1'b0;
                unique case (state_q)
                    RELEASED: begin
                        if (db_rise[gi]) begin
                            state_d = HOLD;
                            rep_d   = '0;
                            fire    = 1'b1;
                        end
                    end
                    HOLD: begin
                        if (db_fall[gi]) begin
                            state_d = RELEASED;
                            rep_d   = '0;
                        end else if (CAN_REPEAT && !freeze) begin
                            if (rep_q == RD_LAST) begin
                                state_d = REPEAT;
                                rep_d   = '0;
                                fire    = 1'b1;
                            end else begin
                                rep_d = rep_q + CNT_W'(1);
                            end
                        end
                    end
                    REPEAT: begin
                        if (db_fall[gi]) begin
                            state_d = RELEASED;
                            rep_d   = '0;
                        end else if (!freeze) begin
                            if (rep_q == RR_LAST) begin
                                rep_d = '0;
                                fire  = 1'b1;
                            end else begin
                                rep_d = rep_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = RELEASED;
                        rep_d   = '0;
                    end
                endcase
                // A hold that overlaps any disabled cycle stays silent until the key is released.
                mute_d = (state_d != RELEASED) && (mute_q || !enable);
            end

            always_ff @(posedge pclk) begin
                if (rst) begin
                    state_q <= RELEASED;
                    rep_q   <= '0;
                    mute_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    rep_q   <= rep_d;
                    mute_q  <= mute_d;
                end
            end

            assign set_pend[gi] = fire & enable & ~mute_d & ~freeze;
        end
    endgenerate

    always_comb begin
        grant = '0;
        if (enable) begin
            if (pend_q[0]) begin
                grant = 4'b0001;
            end else if (pend_q[1]) begin
                grant = 4'b0010;
            end else if (pend_q[2]) begin
                grant = 4'b0100;
            end else if (pend_q[3]) begin
                grant = 4'b1000;
            end
        end
        pend_d = enable ? ((pend_q & ~grant) | set_pend) : '0;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            pend_q <= '0;
            out_q  <= '0;
        end else begin
            pend_q <= pend_d;
            out_q  <= grant;
        end
    end

    assign button_left   = out_q[0];
    assign button_right  = out_q[1];
    assign button_down   = out_q[2];
    assign button_rotate = out_q[3];

endmodule
